// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO switch/LED controller: register offsets and default window base.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd4096;

  typedef enum logic [1:0] {
    OFF_SW   = 2'd0,
    OFF_LED  = 2'd1,
    OFF_EDGE = 2'd2,
    OFF_MASK = 2'd3
  } reg_off_e;

endpackage

// File: rtl/io_debounce.sv
// One switch bit: 2-flop synchronizer feeding the SW_DATA bit flop.
// With MMIO_DEBOUNCE_EN the bit only follows after DEBOUNCE_CYC stable cycles.
module io_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sw,
  output logic o_q,
  output logic o_chg
);

  logic r_s1;
  logic r_s2;
  logic r_q;
  logic w_chg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_sw;
      r_s2 <= r_s1;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter holds the number of prior consecutive mismatching cycles.
  assign w_chg = (r_s2 != r_q) && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if ((r_s2 == r_q) || w_chg) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_chg = (r_s2 != r_q);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else if (w_chg) begin
      r_q <= r_s2;
    end
  end

  assign o_q   = r_q;
  assign o_chg = w_chg;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped switch/LED block: SW_DATA, LED, EDGE (W1C) and MASK registers with irq.
// Optional switch debouncing enabled by defining MMIO_DEBOUNCE_EN.
module mmio_io_ctrl
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int unsigned SW_W         = 16,
  parameter int unsigned LED_W        = 16,
  parameter int unsigned DEBOUNCE_CYC = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic              i_wren,
  input  logic [SW_W-1:0]   i_sw,
  output logic [31:0]       o_rdata,
  output logic              o_rsel,
  output logic [LED_W-1:0]  o_led,
  output logic              o_irq
);

  logic [31:0]      w_off_full;
  logic             w_hit;
  reg_off_e         w_off;
  logic [SW_W-1:0]  w_sw_q;
  logic [SW_W-1:0]  w_sw_chg;
  logic [SW_W-1:0]  w_clr;
  logic [31:0]      w_rd;
  logic             w_wr_led;
  logic             w_wr_mask;

  logic [31:0]      r_rdata;
  logic             r_rsel;
  logic [LED_W-1:0] r_led;
  logic [SW_W-1:0]  r_edge;
  logic [SW_W-1:0]  r_mask;
  logic             r_irq;

  // Unsigned subtract keeps the window test free of BASE_ADDR+3 overflow.
  assign w_off_full = i_addr - BASE_ADDR;
  assign w_hit      = (w_off_full < 32'd4);
  assign w_off      = reg_off_e'(w_off_full[1:0]);
  assign w_wr_led   = i_wren && w_hit && (w_off == OFF_LED);
  assign w_wr_mask  = i_wren && w_hit && (w_off == OFF_MASK);
  assign w_clr      = (i_wren && w_hit && (w_off == OFF_EDGE)) ? i_wdata[SW_W-1:0] : '0;

  for (genvar g = 0; g < SW_W; g++) begin : g_sw
    io_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_sw   (i_sw[g]),
      .o_q    (w_sw_q[g]),
      .o_chg  (w_sw_chg[g])
    );
  end

  always_comb begin
    w_rd = '0;
    unique case (w_off)
      OFF_SW:   w_rd = 32'(w_sw_q);
      OFF_LED:  w_rd = 32'(r_led);
      OFF_EDGE: w_rd = 32'(r_edge);
      OFF_MASK: w_rd = 32'(r_mask);
      default:  w_rd = '0;
    endcase
  end

  // EDGE read samples the pre-clear value; a concurrent new edge beats the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
      r_rsel  <= 1'b0;
      r_led   <= '0;
      r_edge  <= '0;
      r_mask  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_rsel  <= w_hit;
      r_rdata <= w_hit ? w_rd : '0;
      r_edge  <= (r_edge & ~w_clr) | w_sw_chg;
      r_irq   <= |(r_edge & r_mask);
      if (w_wr_led)  r_led  <= i_wdata[LED_W-1:0];
      if (w_wr_mask) r_mask <= i_wdata[SW_W-1:0];
    end
  end

  assign o_rdata = r_rdata;
  assign o_rsel  = r_rsel;
  assign o_led   = r_led;
  assign o_irq   = r_irq;

endmodule

// File: doc/mmio_io_ctrl.md
MMIO_IO_CTRL -- requirements
Module: mmio_io_ctrl

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'd4096: word address of register 0 in the memory-mapped window.
REQ-002 SHALL provide parameter SW_W, default 16: number of switch input bits (1..32).
REQ-003 SHALL provide parameter LED_W, default 16: number of LED output bits (1..32).
REQ-004 SHALL provide parameter DEBOUNCE_CYC, default 1000: cycles of stability required per switch bit (>=1).
REQ-005 clock  input  1  single system clock; all logic on posedge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 addr  input  32  processor data-memory word address.
REQ-008 wdata  input  32  processor store data.
REQ-009 wren  input  1  processor store strobe.
REQ-010 sw  input  SW_W  raw asynchronous switch pins.
REQ-011 rdata  output  32  registered read data, 0 when no hit.
REQ-012 rsel  output  1  registered: previous-cycle addr hit the window; steers processor read mux.
REQ-013 led  output  LED_W  registered LED drive.
REQ-014 irq  output  1  registered OR of (EDGE & MASK).

Function
REQ-015 Window SHALL be 4 words: off0 SW_DATA (RO), off1 LED (RW), off2 EDGE (RO, W1C), off3 MASK (RW); hit = wren-independent addr in [BASE_ADDR, BASE_ADDR+3].
REQ-016 Read latency SHALL be 1 cycle: rdata/rsel updated at posedge from addr sampled that edge; unused upper bits zero-filled.
REQ-017 Store with hit at off1 SHALL load led <= wdata[LED_W-1:0] at that posedge; off3 loads MASK <= wdata[SW_W-1:0].
REQ-018 Store at off0 SHALL be ignored; store outside window SHALL change nothing.
REQ-019 Each sw bit SHALL pass a 2-flop synchronizer before any use.
REQ-020 Filtered switch value SHALL be latched into SW_DATA; a bit change in SW_DATA SHALL set the corresponding EDGE bit (both rising and falling) the same cycle.
REQ-021 Store at off2 SHALL clear EDGE bits where wdata bit = 1; if a new edge on the same bit occurs that cycle, set SHALL win.
REQ-022 irq SHALL assert the cycle after (EDGE & MASK) becomes nonzero and deassert the cycle after it becomes zero.
REQ-023 Read of off2 in the same cycle as its W1C store SHALL return the pre-clear value.

Reset
REQ-024 While reset=0: led=0, rdata=0, rsel=0, irq=0, MASK=0, EDGE=0, synchronizer flops=0, SW_DATA=0, debounce counters=0; asynchronous assertion, synchronous release.
REQ-025 Switch bits already high at release SHALL produce one EDGE set per bit once filtered (MASK=0 suppresses irq).

Configuration
REQ-026 Macro MMIO_DEBOUNCE_EN defined: per bit, SW_DATA changes only after synchronized input differs from SW_DATA for DEBOUNCE_CYC consecutive cycles; counter resets on any reversion.
REQ-027 Macro MMIO_DEBOUNCE_EN undefined: SW_DATA = synchronized input registered once (total 3-cycle pin-to-SW_DATA latency); DEBOUNCE_CYC ignored, no counters built.

Structure
REQ-028 Package mmio_pkg SHALL hold offset constants OFF_SW=0, OFF_LED=1, OFF_EDGE=2, OFF_MASK=3 and default BASE_ADDR.
REQ-029 Sub-module io_debounce (one bit: synchronizer + optional counter, parameter DEBOUNCE_CYC) SHALL be instantiated SW_W times via generate.

Verification
REQ-030 Store wdata=32'h0000_A5A5 at 4097, then load 4097 -> led=16'hA5A5 next cycle; rdata=32'h0000_A5A5, rsel=1 one cycle after load address.
REQ-031 Store 32'hFFFF at 4096, then load 4096 with sw=0 -> SW_DATA unchanged, rdata=0.
REQ-032 DEBOUNCE_EN, DEBOUNCE_CYC=4: sw[3] pulses high 3 cycles -> no EDGE; held 6 cycles -> EDGE[3]=1 after 2+4 cycles.
REQ-033 MASK=16'h0008, EDGE[3] set -> irq=1 next cycle; store 32'h8 at 4098 -> irq=0 cycle after; concurrent new edge on bit 3 -> EDGE[3] stays 1.
REQ-034 Load 4100 -> rsel=0, rdata=0; drop reset mid-store -> led, MASK, EDGE, irq zero immediately, no clock needed.
